aes_block_packer: RTL

Read-side companion to the 256-byte input FIFO: drains bytes from the FIFO read port and assembles them into 128-bit AES blocks for the AES128 core. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency and presents each finished block on a valid/ready handshake. A flush request closes a partial block with zero padding.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_block_packer_if.sv | 43 ++++
 rtl/aes_block_packer.sv | 102 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath package: block geometry and packer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BYTE_W      = 8;
    localparam int AES_BLOCK_BYTES = 16;
    localparam int AES_BLOCK_W     = AES_BLOCK_BYTES * AES_BYTE_W;
    // Byte counts run 0..16 inclusive, hence one bit more than log2(16).
    localparam int AES_NB_W        = 5;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/aes_block_packer_if.sv
// FIFO read port plus AES block handshake seen by the block packer.
// Latency: n/a (wires only).
// Backpressure: blk_valid/blk_ready on the block side; fifo_empty gates reads.
//
// Ports (master = packer side):
//   fifo_dout/fifo_empty in, fifo_rd_en out   - FIFO read port, 1-cycle read data
//   flush in                                  - close the current partial block
//   blk_valid/blk_data/blk_nbytes out, blk_ready in - block handshake
interface aes_block_packer_if;
    import aes_pkg::*;

    logic [AES_BYTE_W-1:0]  fifo_dout;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic                   flush;
    logic                   blk_ready;
    logic                   blk_valid;
    logic [AES_BLOCK_W-1:0] blk_data;
    logic [AES_NB_W-1:0]    blk_nbytes;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  flush,
        input  blk_ready,
        output fifo_rd_en,
        output blk_valid,
        output blk_data,
        output blk_nbytes
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output flush,
        output blk_ready,
        input  fifo_rd_en,
        input  blk_valid,
        input  blk_data,
        input  blk_nbytes
    );

endinterface

// File: rtl/aes_block_packer.sv
// Drains bytes from the input FIFO and packs them MSB-first into 128-bit AES blocks.
// Latency: read strobe N, capture end of N+1; full block valid 17 cycles after first strobe.
// Backpressure: block held stable with reads stopped until blk_ready; empty FIFO stalls issue.
//
// Ports: clk, rst (sync, active high); bus (master modport) carries the FIFO read
// port, the flush request and the block valid/ready handshake.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int DWIDTH    = AES_BYTE_W,
    parameter int BLK_BYTES = AES_BLOCK_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    aes_block_packer_if.master bus
);

    localparam logic [AES_NB_W-1:0] FULL_CNT = AES_NB_W'(BLK_BYTES);

    pack_state_t            state;
    logic [AES_NB_W-1:0]    iss_cnt;     // reads issued into this block
    logic [AES_NB_W-1:0]    rcv_cnt;     // bytes landed in this block
    logic                   rd_pend;     // a read was issued last cycle; data on fifo_dout now
    logic                   flush_pend;  // flush accepted, waiting for outstanding reads
    logic                   blk_valid;
    logic [AES_BLOCK_W-1:0] blk_data;
    logic [AES_NB_W-1:0]    blk_nbytes;

    logic                   rd_en;
    logic [AES_NB_W-1:0]    rcv_nxt;
    logic                   fill_done;
    logic [6:0]             cap_lsb;

    always_comb begin
        // Gated by empty, so every strobe is accepted; never asserted in HOLD,
        // which keeps blk_ready out of the read path.
        rd_en     = (state == FILL) && !bus.fifo_empty && (iss_cnt < FULL_CNT) && !flush_pend;
        rcv_nxt   = rcv_cnt + AES_NB_W'(rd_pend);
        // Close on the 16th landing byte, or on a pending flush once every issued
        // read has landed. rcv_cnt>0 keeps empty blocks from ever being emitted.
        fill_done = (rcv_nxt == FULL_CNT) ||
                    (flush_pend && !rd_pend && (rcv_cnt != '0));
        // First byte goes to the top of the block.
        cap_lsb   = 7'((BLK_BYTES - 1 - int'(rcv_cnt)) * DWIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            iss_cnt    <= '0;
            rcv_cnt    <= '0;
            rd_pend    <= 1'b0;
            flush_pend <= 1'b0;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_nbytes <= '0;
        end else begin
            case (state)
                FILL: begin
                    rd_pend <= rd_en;
                    if (rd_en) begin
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                    if (rd_pend) begin
                        blk_data[cap_lsb +: DWIDTH] <= bus.fifo_dout;
                        rcv_cnt                     <= rcv_nxt;
                    end
                    // A flush before any read was issued has nothing to close.
                    if (bus.flush && (iss_cnt != '0)) begin
                        flush_pend <= 1'b1;
                    end
                    // Placed last so entering HOLD clears flush_pend even if a
                    // new flush arrives in the same cycle.
                    if (fill_done) begin
                        state      <= HOLD;
                        blk_valid  <= 1'b1;
                        blk_nbytes <= rcv_nxt;
                        flush_pend <= 1'b0;
                    end
                end
                HOLD: begin
                    rd_pend <= 1'b0;
                    if (blk_valid && bus.blk_ready) begin
                        state      <= FILL;
                        blk_valid  <= 1'b0;
                        blk_data   <= '0;
                        blk_nbytes <= '0;
                        iss_cnt    <= '0;
                        rcv_cnt    <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.blk_valid  = blk_valid;
    assign bus.blk_data   = blk_data;
    assign bus.blk_nbytes = blk_nbytes;

endmodule
